rc4_ksa: RTL and testbench
==========================

Name: rc4_ksa

Overview:
- Key-scheduling front end of the RC4 datapath. Sits directly upstream of the keystream/PRGA stage.
- Captures the serial key stream (key_valid/key_in) and runs the RC4 KSA over an internal 256x8 S-box.
- After completion, it hands the permuted S-box to the downstream stage through a two-read, swap-capable access port.
- Raises ksa_done once; the downstream stage starts plain/cipher processing only after ksa_done.

Parameters:
- KEY_MAX, 32: maximum stored key bytes; further bytes are ignored.
- KLEN_W, 6: width of key_len; must hold KEY_MAX.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  key byte qualifier; high for consecutive cycles, one byte per cycle.
- key_in  in  8  key byte, sampled at posedge when key_valid=1.
- ksa_done  out  1  S-box permuted and owned by downstream; sticky until rst.
- key_len  out  KLEN_W  number of key bytes captured (1..KEY_MAX).
- s_addr_a  in  8  downstream read/swap address A.
- s_addr_b  in  8  downstream read/swap address B.
- s_rdata_a  out  8  combinational S[s_addr_a]; 0 while ksa_done=0.
- s_rdata_b  out  8  combinational S[s_addr_b]; 0 while ksa_done=0.
- s_swap  in  1  at posedge, exchange S[s_addr_a] and S[s_addr_b]; honoured only when ksa_done=1.

Behaviour:
- Reset (rst=1 at posedge, any state): state<=IDLE, ksa_done<=0, key_len<=0, i/j/k<=0. Key buffer and S contents are don't-care; outputs s_rdata_a/b=0.
- IDLE:
  - key_valid=1: store key_in in K[0], key_len<=1, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - key_valid=1 and key_len<KEY_MAX: K[key_len]<=key_in, key_len++.
  - key_valid=1 and key_len==KEY_MAX: byte dropped, key_len holds at KEY_MAX.
  - key_valid=0: go to INIT. key_in is don't-care from here on.
- INIT (exactly 1 cycle): S[x]<=x for all x in 0..255; i<=0, j<=0, k<=0; go to MIX.
- MIX (exactly 256 cycles, one iteration per cycle):
  - jn = (j + S[i] + K[k]) mod 256, using 8-bit wrap arithmetic.
  - Swap S[i] and S[jn] in the same edge; jn==i leaves S unchanged.
  - j<=jn.
  - k<=(k+1==key_len) ? 0 : k+1. The key repeats modulo key_len; a 1-byte key uses K[0] every cycle.
  - i<=i+1. On the edge where i==255: go to DONE, ksa_done<=1.
- DONE: ksa_done=1; s_rdata_a/b reflect live S.
  - s_swap=1: exchange the two addressed entries in one edge. Equal addresses: no change.
  - key_valid is ignored until rst.
- key_valid asserted during INIT or MIX: ignored; no re-capture.
- Latency: sample edge E0 is the first posedge with key_valid=0 while in LOAD. ksa_done goes high after edge E0+257: 1 INIT edge + 256 MIX edges.
- S-box stays a permutation of 0..255 at every cycle from INIT onward.
- Reset mid-LOAD/INIT/MIX/DONE aborts immediately. A new key may follow with key_valid=1 on the cycle after rst deasserts.
- s_swap and s_addr_* are ignored before ksa_done.

Test Plan:
- Key "Key" (4B 65 79, 3 cycles) -> key_len=3; ksa_done exactly 257 cycles after E0. Bench PRGA model driving s_addr/s_swap yields keystream EB 9F 77 81 B7 34 CA 72 A7 19.
- Key "Wiki" (57 69 6B 69) -> keystream 60 44 DB 6D 41 B7. Key "Secret" (53 65 63 72 65 74) -> keystream 04 D4 6B 05 3C A8 7B 59.
- 40-byte key stream -> key_len=32; S-box identical to a run with only the first 32 bytes.
- 1-byte key 00 -> ksa_done after 257 cycles; reading all 256 entries through s_rdata_a gives each value 0..255 exactly once.
- rst pulsed at MIX cycle 100 -> ksa_done stays 0, s_rdata_a=0. Reload with "Wiki" -> correct keystream 60 44 DB...
- After ksa_done: swap with s_addr_a=s_addr_b=5 -> S unchanged. s_swap with ksa_done=0 and key_valid pulsed in DONE -> both ignored; S and key_len unchanged.

Source files
------------

// File: rtl/rc4_ksa_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rc4_ksa_if: key-capture and S-box access bundle between the RC4 KSA and   |
// |             its downstream PRGA consumer.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface rc4_ksa_if #(
  parameter int KLEN_W = 6
) ();
  logic              key_valid;
  logic [7:0]        key_in;
  logic              ksa_done;
  logic [KLEN_W-1:0] key_len;
  logic [7:0]        s_addr_a;
  logic [7:0]        s_addr_b;
  logic [7:0]        s_rdata_a;
  logic [7:0]        s_rdata_b;
  logic              s_swap;

  // slave is the KSA block; master is the key source plus downstream PRGA
  modport slave (
    input  key_valid, key_in, s_addr_a, s_addr_b, s_swap,
    output ksa_done, key_len, s_rdata_a, s_rdata_b
  );

  modport master (
    output key_valid, key_in, s_addr_a, s_addr_b, s_swap,
    input  ksa_done, key_len, s_rdata_a, s_rdata_b
  );
endinterface
`default_nettype wire

// File: rtl/rc4_ksa.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rc4_ksa: captures a serial RC4 key, runs the key schedule over a 256x8    |
// |          S-box, then exposes it through a two-read swap port.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rc4_ksa #(
  parameter int KEY_MAX = 32,
  parameter int KLEN_W  = 6
) (
  input  logic           clk,
  input  logic           rst,
  rc4_ksa_if.slave       bus
);

  localparam int                c_kidx_w  = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam logic [KLEN_W-1:0] c_key_max = KLEN_W'(KEY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_MIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [KLEN_W-1:0] key_len_q, key_len_d;
  logic [KLEN_W-1:0] k_q, k_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic              done_q, done_d;

  logic [7:0]        s_q   [256];
  logic [7:0]        key_q [KEY_MAX];

  logic              w_key_wr;
  logic [c_kidx_w-1:0] w_key_idx;
  logic              w_s_init;
  logic              w_s_swap;
  logic [7:0]        w_swap_a;
  logic [7:0]        w_swap_b;
  logic [7:0]        w_jn;
  logic [KLEN_W-1:0] w_k_inc;

  always_comb begin
    w_jn    = j_q + s_q[i_q] + key_q[k_q[c_kidx_w-1:0]];
    w_k_inc = k_q + KLEN_W'(1);

    state_d   = state_q;
    key_len_d = key_len_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    done_d    = done_q;
    w_key_wr  = 1'b0;
    w_key_idx = '0;
    w_s_init  = 1'b0;
    w_s_swap  = 1'b0;
    w_swap_a  = 8'h00;
    w_swap_b  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          w_key_wr  = 1'b1;
          key_len_d = KLEN_W'(1);
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.key_valid) begin
          // bytes beyond KEY_MAX are silently dropped
          if (key_len_q < c_key_max) begin
            w_key_wr  = 1'b1;
            w_key_idx = key_len_q[c_kidx_w-1:0];
            key_len_d = key_len_q + KLEN_W'(1);
          end
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        w_s_init = 1'b1;
        i_d      = 8'h00;
        j_d      = 8'h00;
        k_d      = '0;
        state_d  = ST_MIX;
      end
      ST_MIX: begin
        w_s_swap = 1'b1;
        w_swap_a = i_q;
        w_swap_b = w_jn;
        j_d      = w_jn;
        k_d      = (w_k_inc == key_len_q) ? '0 : w_k_inc;
        i_d      = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.s_swap) begin
          w_s_swap = 1'b1;
          w_swap_a = bus.s_addr_a;
          w_swap_b = bus.s_addr_b;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_len_q <= '0;
      k_q       <= '0;
      i_q       <= 8'h00;
      j_q       <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_len_q <= key_len_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      done_q    <= done_d;
    end
  end

  // Storage arrays carry no reset; their contents are undefined until written.
  always_ff @(posedge clk) begin
    if (!rst && w_key_wr) begin
      key_q[w_key_idx] <= bus.key_in;
    end
  end

  // Equal swap addresses write the same value twice, leaving S unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_s_init) begin
        for (int x = 0; x < 256; x++) begin
          s_q[x] <= x[7:0];
        end
      end else if (w_s_swap) begin
        s_q[w_swap_a] <= s_q[w_swap_b];
        s_q[w_swap_b] <= s_q[w_swap_a];
      end
    end
  end

  assign bus.ksa_done  = done_q;
  assign bus.key_len   = key_len_q;
  assign bus.s_rdata_a = done_q ? s_q[bus.s_addr_a] : 8'h00;
  assign bus.s_rdata_b = done_q ? s_q[bus.s_addr_b] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_rc4_ksa.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rc4_ksa: directed bench for the RC4 key schedule using known-answer    |
// |             keystreams and a behavioural KSA reference.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rc4_ksa;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [7:0] key_mem [0:63];
  logic [7:0] exp_ks  [0:15];
  logic [7:0] model_s [0:255];
  logic [7:0] dut_s   [0:255];

  rc4_ksa_if #(.KLEN_W(6)) bus ();

  rc4_ksa #(.KEY_MAX(32), .KLEN_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_key(input logic [255:0] v, input int n);
    for (int b = 0; b < n; b++) key_mem[b] = v[8*(n-b)-1 -: 8];
  endtask

  task automatic set_exp(input logic [127:0] v, input int n);
    for (int b = 0; b < n; b++) exp_ks[b] = v[8*(n-b)-1 -: 8];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.s_swap = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_key(input int n, input bit drop_rst);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      if (drop_rst && b == 0) rst = 1'b0;
      bus.key_valid = 1'b1;
      bus.key_in    = key_mem[b];
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_in    = 8'hA5;
  endtask

  // First posedge consumed here is E0; returns how many edges after E0 ksa_done rose.
  task automatic wait_done(output int cyc);
    cyc = -1;
    @(posedge clk);
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (bus.ksa_done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic read_sbox();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      bus.s_addr_a = a[7:0];
      #1;
      dut_s[a] = bus.s_rdata_a;
    end
  endtask

  task automatic model_ksa(input int len);
    int         jj;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) model_s[x] = x[7:0];
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(model_s[x]) + int'(key_mem[x % len])) % 256;
      t = model_s[x];
      model_s[x] = model_s[jj];
      model_s[jj] = t;
    end
  endtask

  function automatic int sbox_diffs();
    int d;
    d = 0;
    for (int x = 0; x < 256; x++) if (dut_s[x] !== model_s[x]) d++;
    return d;
  endfunction

  // Downstream PRGA driven through the swap port; compares against exp_ks.
  task automatic run_prga(input int n, input string tag);
    logic [7:0] pi, pj, si, sj, ks, t;
    pi = 8'h00;
    pj = 8'h00;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      pi = pi + 8'd1;
      bus.s_addr_a = pi;
      #1;
      si = bus.s_rdata_a;
      pj = pj + si;
      bus.s_addr_b = pj;
      #1;
      sj = bus.s_rdata_b;
      bus.s_swap = 1'b1;
      @(negedge clk);
      bus.s_swap = 1'b0;
      t = si + sj;
      bus.s_addr_a = t;
      #1;
      ks = bus.s_rdata_a;
      checks++;
      if (ks !== exp_ks[b]) begin
        errors++;
        $display("FAIL %s_ks[%0d]: got %02h expected %02h", tag, b, ks, exp_ks[b]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_in = 8'h00;
    bus.s_swap = 1'b0;
    bus.s_addr_a = 8'h07;
    bus.s_addr_b = 8'hF0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ksa_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.ksa_done); end
    checks++; if (bus.key_len !== 6'd0) begin errors++; $display("FAIL rst_key_len: got %0d expected 0", bus.key_len); end
    checks++; if (bus.s_rdata_a !== 8'h00) begin errors++; $display("FAIL rst_rdata_a: got %02h expected 00", bus.s_rdata_a); end
    checks++; if (bus.s_rdata_b !== 8'h00) begin errors++; $display("FAIL rst_rdata_b: got %02h expected 00", bus.s_rdata_b); end
    rst = 1'b0;
  endtask

  task automatic test_vector(input logic [255:0] kv, input int kn,
                             input logic [127:0] ev, input int en, input string tag);
    int cyc;
    do_reset();
    set_key(kv, kn);
    set_exp(ev, en);
    load_key(kn, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 257) begin errors++; $display("FAIL %s_latency: got %0d expected 257", tag, cyc); end
    checks++; if (bus.key_len !== kn[5:0]) begin errors++; $display("FAIL %s_key_len: got %0d expected %0d", tag, bus.key_len, kn); end
    run_prga(en, tag);
  endtask

  task automatic test_long_key();
    int cyc;
    int d;
    do_reset();
    for (int b = 0; b < 40; b++) key_mem[b] = 8'(b * 37 + 11);
    load_key(40, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 257) begin errors++; $display("FAIL long_latency: got %0d expected 257", cyc); end
    checks++; if (bus.key_len !== 6'd32) begin errors++; $display("FAIL long_key_len: got %0d expected 32", bus.key_len); end
    model_ksa(32);
    read_sbox();
    d = sbox_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL long_sbox: got %0d differing entries expected 0", d); end
  endtask

  task automatic test_one_byte();
    int cyc;
    int bad;
    int cnt [0:255];
    do_reset();
    key_mem[0] = 8'h00;
    load_key(1, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 257) begin errors++; $display("FAIL one_latency: got %0d expected 257", cyc); end
    checks++; if (bus.key_len !== 6'd1) begin errors++; $display("FAIL one_key_len: got %0d expected 1", bus.key_len); end
    read_sbox();
    for (int x = 0; x < 256; x++) cnt[x] = 0;
    for (int x = 0; x < 256; x++) cnt[dut_s[x]]++;
    bad = 0;
    for (int x = 0; x < 256; x++) if (cnt[x] != 1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL one_perm: got %0d values not seen once expected 0", bad); end
    model_ksa(1);
    bad = sbox_diffs();
    checks++; if (bad != 0) begin errors++; $display("FAIL one_sbox: got %0d differing entries expected 0", bad); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    do_reset();
    set_key(256'h4B6579, 3);
    load_key(3, 1'b0);
    @(posedge clk);
    repeat (101) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.s_addr_a = 8'h10;
    @(posedge clk);
    #1;
    checks++; if (bus.ksa_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.ksa_done); end
    checks++; if (bus.s_rdata_a !== 8'h00) begin errors++; $display("FAIL midrst_rdata: got %02h expected 00", bus.s_rdata_a); end
    set_key(256'h57696B69, 4);
    set_exp(128'h6044DB6D41B7, 6);
    load_key(4, 1'b1);
    wait_done(cyc);
    checks++; if (cyc != 257) begin errors++; $display("FAIL midrst_latency: got %0d expected 257", cyc); end
    checks++; if (bus.key_len !== 6'd4) begin errors++; $display("FAIL midrst_key_len: got %0d expected 4", bus.key_len); end
    run_prga(6, "midrst");
  endtask

  task automatic test_done_port();
    int cyc;
    int d;
    logic [7:0] t;
    do_reset();
    set_key(256'h4B6579, 3);
    load_key(3, 1'b0);
    wait_done(cyc);
    model_ksa(3);
    @(negedge clk);
    bus.s_addr_a = 8'd5;
    bus.s_addr_b = 8'd5;
    bus.s_swap = 1'b1;
    @(negedge clk);
    bus.s_swap = 1'b0;
    read_sbox();
    d = sbox_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL swap_same: got %0d differing entries expected 0", d); end
    @(negedge clk);
    bus.s_addr_a = 8'd3;
    bus.s_addr_b = 8'd200;
    bus.s_swap = 1'b1;
    @(negedge clk);
    bus.s_swap = 1'b0;
    t = model_s[3];
    model_s[3] = model_s[200];
    model_s[200] = t;
    read_sbox();
    d = sbox_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL swap_pair: got %0d differing entries expected 0", d); end
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_in = 8'hFF;
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.key_len !== 6'd3) begin errors++; $display("FAIL done_keyvalid_len: got %0d expected 3", bus.key_len); end
    checks++; if (bus.ksa_done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b expected 1", bus.ksa_done); end
    read_sbox();
    d = sbox_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL done_keyvalid_sbox: got %0d differing entries expected 0", d); end
  endtask

  task automatic test_swap_before_done();
    int cyc;
    int d;
    do_reset();
    set_key(256'h536563726574, 6);
    bus.s_addr_a = 8'd0;
    bus.s_addr_b = 8'd1;
    bus.s_swap = 1'b1;
    load_key(6, 1'b0);
    @(posedge clk);
    repeat (50) @(posedge clk);
    #1;
    checks++; if (bus.s_rdata_a !== 8'h00 || bus.ksa_done !== 1'b0) begin
      errors++; $display("FAIL mix_outputs: got rdata=%02h done=%b expected 00/0", bus.s_rdata_a, bus.ksa_done);
    end
    repeat (150) @(posedge clk);
    @(negedge clk);
    bus.s_swap = 1'b0;
    cyc = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (bus.ksa_done === 1'b1) begin cyc = n; break; end
    end
    checks++; if (cyc < 0) begin errors++; $display("FAIL early_swap_done: got timeout expected ksa_done"); end
    model_ksa(6);
    read_sbox();
    d = sbox_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL early_swap_sbox: got %0d differing entries expected 0", d); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_vector(256'h4B6579, 3, 128'hEB9F7781B734CA72A719, 10, "key");
    test_vector(256'h57696B69, 4, 128'h6044DB6D41B7, 6, "wiki");
    test_vector(256'h536563726574, 6, 128'h04D46B053CA87B59, 8, "secret");
    test_long_key();
    test_one_byte();
    test_mid_reset();
    test_done_port();
    test_swap_before_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
